sparse_mac_4lane_acc: RTL and testbench

Downstream consumer of the 4-lane sparse activation selector. Each cycle it takes the four selected 4-bit activations (`sel_4x4b`) and the four matching compressed non-zero 4-bit weights. It multiplies per lane, reduces across lanes, and accumulates beats until a group-end marker. It then emits one saturated partial sum per output channel group to the psum writeback stage, with ready/valid backpressure.

---
 rtl/sparse_mac_4lane_acc_pkg.sv | 41 ++++
 rtl/sparse_mac_4lane_acc_mul.sv | 20 ++
 rtl/sparse_mac_4lane_acc.sv | 112 +++++++++++
 tb/tb_sparse_mac_4lane_acc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sparse_mac_4lane_acc_pkg.sv
// Shared widths and the saturating accumulate helper for the sparse MAC datapath.
package sparse_mac_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned ACT_W  = 4;
  localparam int unsigned WGT_W  = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned SUM_W  = 10;

  typedef struct packed {
    logic signed [31:0] val;
    logic               clamp;
  } sat_res_t;

  // acc + s clamped to the signed range of an acc_w-bit accumulator (acc_w <= 32).
  // The sum is formed one bit wider than the operands so overflow is detected
  // before clamping.
  function automatic sat_res_t sat_add(input logic signed [31:0]      acc,
                                       input logic signed [SUM_W-1:0] s,
                                       input int unsigned             acc_w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sat_res_t           res;
    sum = {acc[31], acc} + {{(33-SUM_W){s[SUM_W-1]}}, s};
    hi  = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (acc_w - 1));
    if (sum > hi) begin
      res.val   = hi[31:0];
      res.clamp = 1'b1;
    end else if (sum < lo) begin
      res.val   = lo[31:0];
      res.clamp = 1'b1;
    end else begin
      res.val   = sum[31:0];
      res.clamp = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sparse_mac_4lane_acc_mul.sv
// One lane multiplier: 4-bit unsigned activation times 4-bit two's-complement weight.
module mul_u4s4
  import sparse_mac_pkg::*;
(
  input  logic        [ACT_W-1:0]  i_act,
  input  logic        [WGT_W-1:0]  i_wgt,
  output logic signed [PROD_W-1:0] o_prod
);

  logic signed [PROD_W-1:0] w_act_ext;
  logic signed [PROD_W-1:0] w_wgt_ext;

  // Zero-extend the activation, sign-extend the weight; the product fits in 8 bits.
  always_comb begin
    w_act_ext = {{(PROD_W-ACT_W){1'b0}}, i_act};
    w_wgt_ext = {{(PROD_W-WGT_W){i_wgt[WGT_W-1]}}, i_wgt};
    o_prod    = w_act_ext * w_wgt_ext;
  end

endmodule

// File: rtl/sparse_mac_4lane_acc.sv
// Two-stage 4-lane sparse MAC: per-lane multiply, then cross-lane reduce and
// group accumulate with saturation; one result per group with ready/valid.
module sparse_mac_4lane_acc
  import sparse_mac_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ACT_W-1:0]  sel_act,
  input  logic [LANES*WGT_W-1:0]  wgt,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_psum,
  output logic [CNT_W-1:0]        out_cnt,
  output logic                    out_sat
);

  logic                     w_stall;
  logic signed [PROD_W-1:0] w_prod [LANES];
  logic signed [PROD_W-1:0] r_p    [LANES];
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sat_flag;
  logic [CNT_W-1:0]         w_cnt_inc;
  sat_res_t                 w_sat;
  logic signed [ACC_W-1:0]  w_nxt;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mul_u4s4 u_mul (
      .i_act  (sel_act[g*ACT_W +: ACT_W]),
      .i_wgt  (wgt[g*WGT_W +: WGT_W]),
      .o_prod (w_prod[g])
    );
  end

  // Stage 1: register masked lane products and beat framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) r_p[i] <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_last;
      for (int unsigned i = 0; i < LANES; i++) r_p[i] <= lane_en[i] ? w_prod[i] : '0;
    end
  end

  // Cross-lane reduction, saturating accumulate and saturating beat count.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_sum = w_sum + {{(SUM_W-PROD_W){r_p[i][PROD_W-1]}}, r_p[i]};
    end
    w_sat     = sat_add(32'(r_acc), w_sum, ACC_W);
    w_nxt     = ACC_W'(w_sat.val);
    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  end

  // Stage 2: group accumulator; a last beat hands off and restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sat_flag <= 1'b0;
    end else if (!w_stall && r_s1_valid) begin
      if (r_s1_last) begin
        r_acc      <= '0;
        r_cnt      <= '0;
        r_sat_flag <= 1'b0;
      end else begin
        r_acc      <= w_nxt;
        r_cnt      <= w_cnt_inc;
        r_sat_flag <= r_sat_flag | w_sat.clamp;
      end
    end
  end

  // Output register: loads on a last beat, drains when accepted, holds while stalled.
  // Not stalled implies the slot is empty or being taken this cycle, so a new
  // result can load with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_psum  <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else if (!w_stall) begin
      if (r_s1_valid && r_s1_last) begin
        out_valid <= 1'b1;
        out_psum  <= w_nxt;
        out_cnt   <= w_cnt_inc;
        out_sat   <= r_sat_flag | w_sat.clamp;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sparse_mac_4lane_acc.sv
// Self-checking bench: table of single-beat groups plus hand-written multi-beat
// sequences; expected results are queued on drive and checked on handshake.
module tb_sparse_mac_4lane_acc;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       sel_act;
  logic [15:0]       wgt;
  logic [3:0]        lane_en;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_psum;
  logic [7:0]        out_cnt;
  logic              out_sat;

  typedef struct {
    logic [15:0] act;
    logic [15:0] wgt;
    logic [3:0]  en;
    int          psum;
  } vec_t;

  typedef struct {
    int psum;
    int cnt;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_cmp;
  int   n_err;

  sparse_mac_4lane_acc #(.ACC_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_act   (sel_act),
    .wgt       (wgt),
    .lane_en   (lane_en),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: compare on handshake, and check the held result while stalled.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got psum %0d, expected no output", out_psum);
      end else if (out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("psum", int'(out_psum), e.psum);
        chk("cnt", int'(out_cnt), e.cnt);
        chk("sat", int'(out_sat), e.sat);
      end else begin
        chk("held_psum", int'(out_psum), exp_q[0].psum);
        chk("held_cnt", int'(out_cnt), exp_q[0].cnt);
      end
    end
  end

  // Drive one beat and wait (bounded) for acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] w,
                      input logic [3:0] en, input logic last);
    int n;
    sel_act  = a;
    wgt      = w;
    lane_en  = en;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input int p, input int c, input int s);
    exp_t e;
    e.psum = p;
    e.cnt  = c;
    e.sat  = s;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{16'hFFFF, 16'h7777, 4'hF, 420};
    vecs[1] = '{16'hFFFF, 16'h8888, 4'hF, -480};
    vecs[2] = '{16'h4321, 16'h1111, 4'hF, 10};
    vecs[3] = '{16'h4321, 16'hFFFF, 4'hF, -10};
    vecs[4] = '{16'hFFFF, 16'h7777, 4'b0101, 210};
    vecs[5] = '{16'h0000, 16'h7777, 4'hF, 0};
    vecs[6] = '{16'h00F3, 16'h0082, 4'b0011, -114};
    vecs[7] = '{16'hA5C1, 16'h9E3F, 4'hF, -45};

    rst = 1'b1; in_valid = 1'b0; sel_act = '0; wgt = '0;
    lane_en = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_psum", int'(out_psum), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Latency: last beat accepted in cycle t -> out_valid in t+2.
    sel_act = 16'hFFFF; wgt = 16'h7777; lane_en = 4'hF; in_last = 1'b1; in_valid = 1'b1;
    push(420, 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("lat_t1_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_t2_valid", int'(out_valid), 1);
    drain();

    // Table of single-beat groups, back-to-back.
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].psum, 1, 0);
      send(vecs[i].act, vecs[i].wgt, vecs[i].en, 1'b1);
    end
    drain();

    // Three-beat masked group.
    push(-474, 3, 0);
    send(16'hFFFF, 16'h8888, 4'hF, 1'b0);
    send(16'hFFF3, 16'h7772, 4'b0001, 1'b0);
    send(16'hFFFF, 16'h7777, 4'b0000, 1'b1);
    drain();

    // Saturation over 80 beats, then a fresh group starts clean.
    push(32767, 80, 1);
    for (int i = 1; i <= 80; i++) send(16'hFFFF, 16'h7777, 4'hF, i == 80);
    push(6, 1, 0);
    send(16'hFFF3, 16'h7772, 4'b0001, 1'b1);
    drain();

    // Backpressure: two results queued while downstream is not ready.
    out_ready = 1'b0;
    push(420, 1, 0);
    send(16'hFFFF, 16'h7777, 4'hF, 1'b1);
    push(-480, 1, 0);
    send(16'hFFFF, 16'h8888, 4'hF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_pending", exp_q.size(), 2);
    out_ready = 1'b1;
    drain();

    // Reset mid-group discards partial accumulation.
    send(16'hFFFF, 16'h7777, 4'hF, 1'b0);
    send(16'hFFFF, 16'h7777, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(6, 1, 0);
    send(16'hFFF3, 16'h7772, 4'b0001, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
